// File: rtl/pool_frame_ctrl_pkg.sv
`default_nettype none
// ---- pool_frame_ctrl_pkg : shared state encoding, error bits, geometry helpers -- rev 1.0 ----
package pool_frame_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int ERR_INPUT = 0;
   localparam int ERR_PROTO = 1;

   // Full-resolution geometry derived from the pooled output geometry
   function automatic int calc_in_w(input int half_width);
      return 2 * half_width;
   endfunction

   function automatic int calc_in_h(input int half_height);
      return 2 * half_height;
   endfunction

   function automatic int calc_n_out(input int half_width, input int half_height);
      return half_width * half_height;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pool_frame_ctrl_raster.sv
`default_nettype none
// ---- raster_counter : col/row raster position with end-of-frame flag -- rev 1.0 ----
module raster_counter #(
   parameter int WIDTH   = 24,
   parameter int HEIGHT  = 24,
   parameter int COL_BIT = 5,
   parameter int ROW_BIT = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               advance,
   output logic [COL_BIT-1:0] col,
   output logic [ROW_BIT-1:0] row,
   output logic               last
);

   localparam logic [COL_BIT-1:0] COL_MAX = COL_BIT'(WIDTH - 1);
   localparam logic [ROW_BIT-1:0] ROW_MAX = ROW_BIT'(HEIGHT - 1);

   assign last = (col == COL_MAX) && (row == ROW_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (clear) begin
         col <= '0;
         row <= '0;
      end else if (advance) begin
         if (col == COL_MAX) begin
            col <= '0;
            row <= (row == ROW_MAX) ? '0 : row + ROW_BIT'(1);
         end else begin
            col <= col + COL_BIT'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pool_frame_ctrl.sv
`default_nettype none
// ---- pool_frame_ctrl : frame sequencer in front of the 2x2 average pooler -- rev 1.0 ----
module pool_frame_ctrl
   import pool_frame_ctrl_pkg::*;
#(
   parameter int HALF_WIDTH  = 12,
   parameter int HALF_HEIGHT = 12,
   parameter int COL_BIT     = 5,
   parameter int ROW_BIT     = 5,
   parameter int OUT_BIT     = 8,
   parameter int CLR_CYCLES  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               conv_valid,
   input  logic               pool_valid_out,
   output logic               pool_rst,
   output logic               pool_valid_in,
   output logic [COL_BIT-1:0] col,
   output logic [ROW_BIT-1:0] row,
   output logic [OUT_BIT-1:0] out_count,
   output logic               busy,
   output logic               frame_done,
   output logic [1:0]         err
);

   localparam int               IN_W    = calc_in_w(HALF_WIDTH);
   localparam int               IN_H    = calc_in_h(HALF_HEIGHT);
   localparam int               N_OUT   = calc_n_out(HALF_WIDTH, HALF_HEIGHT);
   localparam logic [3:0]       CLR_MAX = 4'(CLR_CYCLES - 1);
   localparam logic [OUT_BIT-1:0] OUT_FULL = OUT_BIT'(N_OUT);

   state_t     state;
   state_t     next_state;
   logic [3:0] clr_cnt;
   logic       last_beat;
   logic       frame_start;
   logic       count_en;
   logic [1:0] err_set;
   logic       pool_rst_d;
   logic       busy_d;
   logic       frame_done_d;

   assign frame_start = (state == ST_IDLE) && start;

   raster_counter #(
      .WIDTH   (IN_W),
      .HEIGHT  (IN_H),
      .COL_BIT (COL_BIT),
      .ROW_BIT (ROW_BIT)
   ) u_raster (
      .clk     (clk),
      .rst     (rst),
      .clear   (frame_start),
      .advance (pool_valid_in),
      .col     (col),
      .row     (row),
      .last    (last_beat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (start) next_state = ST_CLEAR;
         ST_CLEAR: if (clr_cnt == CLR_MAX) next_state = ST_RUN;
         ST_RUN: begin
            if (out_count == OUT_FULL)           next_state = ST_DONE;
            else if (pool_valid_in && last_beat) next_state = ST_DRAIN;
         end
         ST_DRAIN: if (out_count == OUT_FULL) next_state = ST_DONE;
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // pool_valid_in stays combinational: the pooler samples conv data in the same cycle
   always_comb begin
      pool_valid_in = (state == ST_RUN) && conv_valid;
      count_en      = pool_valid_out && ((state == ST_RUN) || (state == ST_DRAIN));
      err_set       = '0;
      err_set[ERR_INPUT] = conv_valid &&
                           ((state == ST_CLEAR) || (state == ST_DRAIN) || (state == ST_DONE));
      err_set[ERR_PROTO] = (start && (state != ST_IDLE)) ||
                           (pool_valid_out && (state != ST_RUN) && (state != ST_DRAIN));
      pool_rst_d    = (next_state == ST_CLEAR);
      busy_d        = (next_state == ST_CLEAR) || (next_state == ST_RUN) ||
                      (next_state == ST_DRAIN);
      frame_done_d  = (next_state == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_cnt    <= '0;
         pool_rst   <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         out_count  <= '0;
         err        <= '0;
      end else begin
         clr_cnt    <= (state == ST_CLEAR) ? clr_cnt + 4'd1 : 4'd0;
         pool_rst   <= pool_rst_d;
         busy       <= busy_d;
         frame_done <= frame_done_d;
         if (frame_start) begin
            out_count <= '0;
            err       <= '0;
         end else begin
            if (count_en) out_count <= out_count + OUT_BIT'(1);
            err <= err | err_set;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pool_frame_ctrl.sv
`default_nettype none
// ---- tb_pool_frame_ctrl : scoreboard bench for pool_frame_ctrl on a 4x4 frame -- rev 1.0 ----
`timescale 1ns/1ps
module tb_pool_frame_ctrl;

   localparam int IN_W = 4;

   typedef struct {
      int         cyc;
      logic [1:0] err;
   } done_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       conv_valid = 1'b0;
   logic       pool_valid_out = 1'b0;
   logic       pool_rst;
   logic       pool_valid_in;
   logic [4:0] col;
   logic [4:0] row;
   logic [7:0] out_count;
   logic       busy;
   logic       frame_done;
   logic [1:0] err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [9:0] beat_q[$];
   done_t      done_q[$];

   pool_frame_ctrl #(
      .HALF_WIDTH  (2),
      .HALF_HEIGHT (2),
      .COL_BIT     (5),
      .ROW_BIT     (5),
      .OUT_BIT     (8),
      .CLR_CYCLES  (1)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .conv_valid     (conv_valid),
      .pool_valid_out (pool_valid_out),
      .pool_rst       (pool_rst),
      .pool_valid_in  (pool_valid_in),
      .col            (col),
      .row            (row),
      .out_count      (out_count),
      .busy           (busy),
      .frame_done     (frame_done),
      .err            (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Behavioural 2x2 pooler: one result the cycle after each window-closing beat
   int pcol = 0;
   int prow = 0;
   always @(posedge clk) begin
      if (pool_rst) begin
         pcol <= 0;
         prow <= 0;
         pool_valid_out <= 1'b0;
      end else begin
         pool_valid_out <= pool_valid_in && (pcol % 2 == 1) && (prow % 2 == 1);
         if (pool_valid_in) begin
            pcol <= (pcol == IN_W - 1) ? 0 : pcol + 1;
            if (pcol == IN_W - 1) prow <= (prow == IN_W - 1) ? 0 : prow + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT forwards a beat or ends a frame
   logic [9:0] exp_beat;
   done_t      exp_done;
   always @(negedge clk) begin
      if (pool_valid_in) begin
         if (beat_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=forwarded(col=%0d row=%0d) expected=dropped", col, row);
         end else begin
            exp_beat = beat_q.pop_front();
            chk("beat_col", col, exp_beat[4:0]);
            chk("beat_row", row, exp_beat[9:5]);
         end
      end
      if (frame_done) begin
         if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_done actual=1 expected=0 at cycle %0d", cyc);
         end else begin
            exp_done = done_q.pop_front();
            chk("done_cycle", cyc, exp_done.cyc);
            chk("done_err", err, exp_done.err);
            chk("done_out_count", out_count, 4);
            chk("done_busy", busy, 0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input bit early);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("clear_pool_rst", pool_rst, 1);
      chk("clear_busy", busy, 1);
      if (early) conv_valid = 1'b1;
      tick();
      conv_valid = 1'b0;
      chk("run_pool_rst", pool_rst, 0);
      chk("run_col_start", col, 0);
   endtask

   // Beat i sits at raster (i/4, i%4); frame_done is registered two edges after the last beat's edge
   task automatic feed(input int n, input int gap, input int busy_start_at, input logic [1:0] exp_err);
      for (int i = 0; i < n; i++) begin
         conv_valid = 1'b1;
         if (i < 16) beat_q.push_back({5'(i / IN_W), 5'(i % IN_W)});
         if (i == 15) done_q.push_back('{cyc + 3, exp_err});
         if (i == busy_start_at) start = 1'b1;
         tick();
         conv_valid = 1'b0;
         start = 1'b0;
         repeat (gap) tick();
      end
      for (int k = 0; k < 20 && done_q.size() != 0; k++) tick();
      if (done_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL frame_done_timeout actual=none expected=pulse");
         done_q.delete();
      end
      tick();
      chk("idle_busy", busy, 0);
      chk("beats_left", beat_q.size(), 0);
      beat_q.delete();
   endtask

   initial begin
      #12;
      chk("rst_pool_rst", pool_rst, 1);
      chk("rst_busy", busy, 0);
      chk("rst_col", col, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_err", err, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      chk("rel_pool_rst_held", pool_rst, 1);
      tick();
      chk("rel_pool_rst_drop", pool_rst, 0);

      // Abort mid-RUN at col=2,row=1
      start_frame(0);
      for (int i = 0; i < 6; i++) begin
         conv_valid = 1'b1;
         beat_q.push_back({5'(i / IN_W), 5'(i % IN_W)});
         tick();
         conv_valid = 1'b0;
      end
      chk("pre_abort_col", col, 2);
      chk("pre_abort_row", row, 1);
      #3 rst = 1'b1;
      #1;
      chk("abort_pool_rst", pool_rst, 1);
      chk("abort_busy", busy, 0);
      chk("abort_col", col, 0);
      chk("abort_row", row, 0);
      chk("abort_out_count", out_count, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      chk("abort_rel_pool_rst", pool_rst, 1);
      tick();
      chk("abort_rel_pool_rst_drop", pool_rst, 0);
      beat_q.delete();

      start_frame(0); feed(16, 0, -1, 2'b00);   // back-to-back
      start_frame(0); feed(16, 1, -1, 2'b00);   // gapped
      start_frame(0); feed(17, 0, -1, 2'b01);   // overrun
      start_frame(1); feed(16, 0, -1, 2'b01);   // early input in CLEAR
      start_frame(0); feed(16, 0, 5, 2'b10);    // start while busy
      start_frame(0);
      chk("restart_err_clear", err, 0);
      feed(16, 0, -1, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
